hog_frame_ctrl: RTL and testbench
=================================

# hog_frame_ctrl

Frame-level sequencer for the HOG histogram stage. It accepts a software start pulse and waits for the cell BRAM to be initialised. It then streams exactly one frame of pixels into the histogram datapath (`p`/`p_valid`/`finish`) and waits for `histogram_done`. After that it launches normalization, and finally pulses `write_feature_done` so the cell BRAM is re-initialised for the next frame. It sits between the AXI-Lite register block and the histogram top, with watchdogs on both wait phases.

## Interface
Parameters:
- `IMAGE_SIZE`, 18495: index of the last pixel in a frame (pixel count − 1; 136·136−1).
- `CNT_W`, 15: pixel counter width; must satisfy 2^CNT_W > IMAGE_SIZE.
- `TIMEOUT`, 65535: maximum cycles allowed in DRAIN or NORM before the block declares an error.

Ports:
- `aclk` in 1: clock. One clock; reset is synchronous and active-high.
- `arest` in 1: reset. Synchronous, active-high.
- `start` in 1: one-cycle frame request. Ignored unless state is IDLE, DONE or ERROR.
- `s_pix_data` in 8: upstream pixel.
- `s_pix_valid` in 1: upstream pixel valid.
- `s_pix_ready` out 1: pixel accepted when `s_pix_valid & s_pix_ready`.
- `p` out 8: pixel to the histogram stage.
- `p_valid` out 1: pixel valid to the histogram stage.
- `finish` out 1: marks the last pixel of the frame.
- `hog_ready` in 1: level signal; cell BRAM is initialised.
- `histogram_done` in 1: pulse; histogram accumulation is complete.
- `norm_start` out 1: one-cycle pulse that launches normalization.
- `norm_done` in 1: pulse; normalization is complete.
- `write_feature_done` out 1: one-cycle pulse that triggers cell BRAM re-initialisation.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: one-cycle pulse on entry to DONE.
- `error` out 1: sticky timeout flag; cleared by an accepted `start` or by reset.
- `pix_cnt` out CNT_W: number of pixels accepted in the current frame.
- `frame_cnt` out 16: frames completed; wraps 65535→0.

## Operation
States: IDLE, WAIT_INIT, STREAM, DRAIN, NORM, RELEASE, DONE, ERROR.

- **IDLE / DONE / ERROR**
  - `start` → WAIT_INIT.
  - On that transition: clear `pix_cnt`, clear `error`, clear the watchdog.
- **WAIT_INIT**
  - `hog_ready`=1 → STREAM.
  - No timeout in this state.
- **STREAM**
  - `s_pix_ready`=1 in this state only. It is a registered output, high on every STREAM cycle.
  - Each accepted beat increments `pix_cnt`.
  - The beat accepted while `pix_cnt`==IMAGE_SIZE is the last one; → DRAIN.
  - Stalls on `s_pix_valid`=0 are unlimited.
- **DRAIN**
  - `histogram_done` → NORM, with `norm_start` pulsed on the transition cycle.
  - Watchdog expiry → ERROR.
- **NORM**
  - `norm_done` → RELEASE.
  - Watchdog expiry → ERROR.
- **RELEASE**
  - Lasts one cycle; `write_feature_done`=1 in this state.
  - Then → DONE.
  - `frame_cnt` increments on RELEASE→DONE.
- **DONE**
  - `done`=1 for the entry cycle only.
- **Watchdog**
  - Counts cycles spent in DRAIN or NORM; reset on entry to each of those states.
  - Expiry at count TIMEOUT.
  - `error` is set on entry to ERROR.
  - ERROR never pulses `write_feature_done`; software recovers with reset.
- **Ignored events**
  - `histogram_done` outside DRAIN and `norm_done` outside NORM are ignored.
  - This covers spurious or early pulses.
  - If `histogram_done` and watchdog expiry coincide, `histogram_done` wins. The same rule applies to `norm_done` in NORM.
- **Reset**
  - `arest` at any time, including mid-frame → IDLE next edge.
  - All counters and outputs are cleared.
  - The histogram stage is not reset by this block.

## Timing
- Reset values: all outputs 0 (`p`=0, `pix_cnt`=0, `frame_cnt`=0, `error`=0, `s_pix_ready`=0).
- Pixel path has 1-cycle latency:
  - `p`/`p_valid` are registered copies of the beat accepted on the previous edge.
  - `finish` is registered and high in the same cycle as `p_valid` for pixel index IMAGE_SIZE.
  - `p_valid` is 0 on non-accepted cycles.
- `s_pix_ready` drops in the cycle after the last beat (state = DRAIN). Exactly IMAGE_SIZE+1 beats are accepted per frame.
- `start` → `busy`=1: one cycle.
- `hog_ready` sampled high → `s_pix_ready`=1: next cycle.
- `histogram_done` → `norm_start`=1: same cycle (Mealy pulse, registered out: one cycle later). It is implemented as registered, i.e. `norm_start` is high in the first NORM cycle.
- `norm_done` → `write_feature_done`=1: next cycle. `done`=1 one cycle after that.
- Watchdog: ERROR is entered TIMEOUT+1 cycles after entering DRAIN/NORM if no completion pulse arrives.
- `start` while `busy` is ignored and has no side effect.

## Test plan
- **Full frame.** Reset, `start`, `hog_ready`=1, 18496 back-to-back valid pixels (data = index[7:0]), `histogram_done` 10 cycles later, `norm_done` 20 cycles after that.
  - Exactly 18496 `p_valid` pulses.
  - `finish` only with the last one (`p`=0x3F).
  - One `norm_start`, one `write_feature_done`, one `done`.
  - `frame_cnt`=1, `busy`=0.
- **Init wait and stalls.** `start` with `hog_ready`=0 for 100 cycles, then random `s_pix_valid` gaps.
  - `s_pix_ready`=0 throughout the wait.
  - `pix_cnt` ends at 18496.
  - `p` sequence matches the accepted beats in order.
- **Timeout.** TIMEOUT=100, withhold `histogram_done`.
  - `error`=1 at cycle 101 of DRAIN.
  - No `norm_start`, no `write_feature_done`.
  - A later `start` clears `error`.
  - A second full frame completes with `frame_cnt`=1.
- **Spurious pulses.** `histogram_done` during STREAM; `norm_done` during DRAIN; `start` during NORM.
  - No state change.
  - `pix_cnt` and the frame complete normally.
- **Reset mid-stream.** Assert `arest` after 5000 pixels.
  - Next cycle: all outputs 0, state IDLE.
  - A following `start` streams a full 18496-pixel frame.
- **Coincidence.** `histogram_done` on the exact expiry cycle → NORM is entered and `error` stays 0.

Source files
------------

// File: rtl/hog_frame_ctrl.sv
// Frame-level sequencer for the HOG histogram stage: waits for cell BRAM init, streams one frame,
// waits for histogram and normalization completion, then requests BRAM re-initialisation.
module hog_frame_ctrl #(
  parameter int IMAGE_SIZE = 18495,
  parameter int CNT_W      = 15,
  parameter int TIMEOUT    = 65535
) (
  input  logic             aclk,
  input  logic             arest,
  input  logic             start,
  input  logic [7:0]       s_pix_data,
  input  logic             s_pix_valid,
  output logic             s_pix_ready,
  output logic [7:0]       p,
  output logic             p_valid,
  output logic             finish,
  input  logic             hog_ready,
  input  logic             histogram_done,
  output logic             norm_start,
  input  logic             norm_done,
  output logic             write_feature_done,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] pix_cnt,
  output logic [15:0]      frame_cnt
);

  localparam int               WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMAGE_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_INIT, S_STREAM, S_DRAIN, S_NORM, S_RELEASE, S_DONE, S_ERROR
  } state_e;

  state_e           st_q, st_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic [7:0]       p_q, p_d;
  logic             p_valid_q, p_valid_d;
  logic             finish_q, finish_d;
  logic             norm_start_q, norm_start_d;
  logic             wfd_q, wfd_d;
  logic             done_q, done_d;
  logic             beat, last_beat, wd_expired;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    st_d         = st_q;
    pix_cnt_d    = pix_cnt_q;
    wd_d         = wd_q;
    frame_cnt_d  = frame_cnt_q;
    error_d      = error_q;
    norm_start_d = 1'b0;
    beat         = s_pix_valid & ready_q;
    last_beat    = beat && (pix_cnt_q == LAST_PIX);
    wd_expired   = (wd_q == WD_MAX);

    case (st_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          st_d      = S_WAIT_INIT;
          pix_cnt_d = '0;
          error_d   = 1'b0;
          wd_d      = '0;
        end
      end
      S_WAIT_INIT: if (hog_ready) st_d = S_STREAM;
      S_STREAM: begin
        if (beat) pix_cnt_d = pix_cnt_q + 1'b1;
        if (last_beat) begin
          st_d = S_DRAIN;
          wd_d = '0;
        end
      end
      // Completion pulses take priority over a watchdog expiry in the same cycle.
      S_DRAIN: begin
        if (histogram_done) begin
          st_d         = S_NORM;
          wd_d         = '0;
          norm_start_d = 1'b1;
        end else if (wd_expired) begin
          st_d    = S_ERROR;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_NORM: begin
        if (norm_done) begin
          st_d = S_RELEASE;
        end else if (wd_expired) begin
          st_d    = S_ERROR;
          error_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RELEASE: begin
        st_d        = S_DONE;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      default: st_d = S_IDLE;
    endcase

    ready_d   = (st_d == S_STREAM);
    p_valid_d = beat;
    p_d       = beat ? s_pix_data : p_q;
    finish_d  = last_beat;
    wfd_d     = (st_d == S_RELEASE);
    done_d    = (st_q == S_RELEASE);
  end

  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of order.
    if (arest) begin
      st_q         <= S_IDLE;
      pix_cnt_q    <= '0;
      wd_q         <= '0;
      frame_cnt_q  <= '0;
      error_q      <= 1'b0;
      ready_q      <= 1'b0;
      p_q          <= '0;
      p_valid_q    <= 1'b0;
      finish_q     <= 1'b0;
      norm_start_q <= 1'b0;
      wfd_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      st_q         <= st_d;
      pix_cnt_q    <= pix_cnt_d;
      wd_q         <= wd_d;
      frame_cnt_q  <= frame_cnt_d;
      error_q      <= error_d;
      ready_q      <= ready_d;
      p_q          <= p_d;
      p_valid_q    <= p_valid_d;
      finish_q     <= finish_d;
      norm_start_q <= norm_start_d;
      wfd_q        <= wfd_d;
      done_q       <= done_d;
    end
  end

  assign s_pix_ready        = ready_q;
  assign p                  = p_q;
  assign p_valid            = p_valid_q;
  assign finish             = finish_q;
  assign norm_start         = norm_start_q;
  assign write_feature_done = wfd_q;
  assign done               = done_q;
  assign error              = error_q;
  assign pix_cnt            = pix_cnt_q;
  assign frame_cnt          = frame_cnt_q;
  assign busy               = !(st_q inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Self-checking bench for hog_frame_ctrl: small frame and timeout, randomized pixel gaps and data,
// pixel path checked beat-by-beat against the accepted stream, phase outputs against a frame model.
module tb_hog_frame_ctrl;

  localparam int IMG = 63;
  localparam int CW  = 7;
  localparam int TO  = 100;

  logic          aclk = 1'b0;
  logic          arest = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    s_pix_data = '0;
  logic          s_pix_valid = 1'b0;
  logic          s_pix_ready;
  logic [7:0]    p;
  logic          p_valid, finish;
  logic          hog_ready = 1'b0;
  logic          histogram_done = 1'b0;
  logic          norm_start;
  logic          norm_done = 1'b0;
  logic          write_feature_done, busy, done, error;
  logic [CW-1:0] pix_cnt;
  logic [15:0]   frame_cnt;

  hog_frame_ctrl #(.IMAGE_SIZE(IMG), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .aclk(aclk), .arest(arest), .start(start),
    .s_pix_data(s_pix_data), .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .p(p), .p_valid(p_valid), .finish(finish),
    .hog_ready(hog_ready), .histogram_done(histogram_done),
    .norm_start(norm_start), .norm_done(norm_done),
    .write_feature_done(write_feature_done), .busy(busy), .done(done), .error(error),
    .pix_cnt(pix_cnt), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference for the pixel path: each accepted beat must reappear on p one cycle later.
  logic       pend = 1'b0, pend_last = 1'b0;
  logic [7:0] pend_data = '0, fin_p = '0;
  int         beat_idx = 0;
  int         pv_n = 0, fin_n = 0, ns_n = 0, wfd_n = 0, done_n = 0;

  always @(posedge aclk) begin
    pend      = 1'b0;
    pend_last = 1'b0;
    if (arest || start) begin
      beat_idx = 0;
    end else if (s_pix_valid && s_pix_ready) begin
      pend      = 1'b1;
      pend_data = s_pix_data;
      pend_last = (beat_idx == IMG);
      beat_idx++;
    end
  end

  always @(negedge aclk) begin
    check("p_valid", p_valid, pend);
    check("finish", finish, pend_last);
    if (pend) check("p", p, pend_data);
    if (finish) fin_p = p;
    pv_n   += int'(p_valid);
    fin_n  += int'(finish);
    ns_n   += int'(norm_start);
    wfd_n  += int'(write_feature_done);
    done_n += int'(done);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge aclk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends n beats with gap_pct% idle cycles; returns on the negedge after the last accepted beat.
  task automatic stream(input int n, input int gap_pct, input bit idx_data);
    int sent  = 0;
    int guard = 0;
    while (sent < n && guard < 20000) begin
      s_pix_valid = ($urandom_range(99) >= gap_pct);
      s_pix_data  = idx_data ? 8'(sent) : 8'($urandom);
      @(posedge aclk);
      if (s_pix_valid && s_pix_ready) sent++;
      @(negedge aclk);
      guard++;
    end
    s_pix_valid = 1'b0;
    check("stream_bound", guard < 20000, 1);
  endtask

  // Starts in the first DRAIN cycle and completes the frame.
  task automatic finish_frame(input int hd_dly, input int nd_dly);
    tick(hd_dly);
    histogram_done = 1'b1;
    tick();
    histogram_done = 1'b0;
    check("norm_start", norm_start, 1);
    tick(nd_dly);
    norm_done = 1'b1;
    tick();
    norm_done = 1'b0;
    check("wfd", write_feature_done, 1);
    tick();
    exp_frames++;
    check("done", done, 1);
    check("frame_cnt", frame_cnt, exp_frames);
    tick();
    check("done_once", done, 0);
    check("busy_end", busy, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_p"}, p, 0);
    check({tag, "_ready"}, s_pix_ready, 0);
    check({tag, "_ns"}, norm_start, 0);
    check({tag, "_wfd"}, write_feature_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_pix_cnt"}, pix_cnt, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    int pv0, fin0, ns0, wfd0, done0, ready_hi;

    tick(2);
    arest = 1'b0;
    check_cleared("rst");

    // Full frame, back-to-back, data = index.
    hog_ready = 1'b1;
    pv0 = pv_n; fin0 = fin_n; ns0 = ns_n; wfd0 = wfd_n; done0 = done_n;
    pulse_start();
    check("start_busy", busy, 1);
    stream(IMG + 1, 0, 1'b1);
    check("drain_ready", s_pix_ready, 0);
    check("drain_pix_cnt", pix_cnt, IMG + 1);
    finish_frame(9, 19);
    check("full_pv", pv_n - pv0, IMG + 1);
    check("full_fin", fin_n - fin0, 1);
    check("full_fin_p", fin_p, 8'h3F);
    check("full_ns", ns_n - ns0, 1);
    check("full_wfd", wfd_n - wfd0, 1);
    check("full_done", done_n - done0, 1);

    // Init wait, then random stalls.
    hog_ready = 1'b0;
    pulse_start();
    ready_hi = 0;
    for (int i = 0; i < 100; i++) begin
      ready_hi += int'(s_pix_ready);
      tick();
    end
    check("wait_ready", ready_hi, 0);
    check("wait_busy", busy, 1);
    hog_ready = 1'b1;
    stream(IMG + 1, 40, 1'b0);
    check("stall_pix_cnt", pix_cnt, IMG + 1);
    finish_frame(3, 3);

    // DRAIN timeout.
    pulse_start();
    stream(IMG + 1, 10, 1'b0);
    ns0 = ns_n; wfd0 = wfd_n;
    tick(TO);
    check("to_err_early", error, 0);
    check("to_busy_early", busy, 1);
    tick();
    check("to_error", error, 1);
    check("to_busy", busy, 0);
    tick(3);
    check("to_sticky", error, 1);
    check("to_ns", ns_n - ns0, 0);
    check("to_wfd", wfd_n - wfd0, 0);
    check("to_frame_cnt", frame_cnt, exp_frames);
    pulse_start();
    check("to_err_clr", error, 0);
    stream(IMG + 1, 10, 1'b0);
    finish_frame(5, 5);

    // Spurious pulses.
    pulse_start();
    stream(32, 20, 1'b0);
    histogram_done = 1'b1;
    tick();
    histogram_done = 1'b0;
    check("sp_hd_ready", s_pix_ready, 1);
    check("sp_hd_ns", norm_start, 0);
    stream(IMG + 1 - 32, 20, 1'b0);
    check("sp_pix_cnt", pix_cnt, IMG + 1);
    norm_done = 1'b1;
    tick();
    norm_done = 1'b0;
    check("sp_nd_wfd", write_feature_done, 0);
    check("sp_nd_busy", busy, 1);
    histogram_done = 1'b1;
    tick();
    histogram_done = 1'b0;
    check("sp_ns", norm_start, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sp_st_busy", busy, 1);
    check("sp_st_pix_cnt", pix_cnt, IMG + 1);
    check("sp_st_wfd", write_feature_done, 0);
    norm_done = 1'b1;
    tick();
    norm_done = 1'b0;
    check("sp_wfd", write_feature_done, 1);
    tick();
    exp_frames++;
    check("sp_done", done, 1);
    check("sp_frame_cnt", frame_cnt, exp_frames);

    // Reset mid-stream.
    pulse_start();
    stream(20, 0, 1'b0);
    s_pix_valid = 1'b1;
    arest = 1'b1;
    tick();
    check_cleared("mid");
    check("mid_p_valid", p_valid, 0);
    s_pix_valid = 1'b0;
    arest = 1'b0;
    exp_frames = 0;
    pulse_start();
    stream(IMG + 1, 15, 1'b0);
    check("mid_pix_cnt", pix_cnt, IMG + 1);
    finish_frame(2, 2);

    // Completion pulses coinciding with watchdog expiry in DRAIN and NORM.
    pulse_start();
    stream(IMG + 1, 0, 1'b0);
    finish_frame(TO, TO);
    check("co_error", error, 0);

    // NORM timeout.
    pulse_start();
    stream(IMG + 1, 0, 1'b0);
    histogram_done = 1'b1;
    tick();
    histogram_done = 1'b0;
    tick(TO);
    check("nto_err_early", error, 0);
    tick();
    check("nto_error", error, 1);
    check("nto_wfd", write_feature_done, 0);
    check("nto_frame_cnt", frame_cnt, exp_frames);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
